pipe_ctrl_n: RTL and testbench
==============================

# pipe_ctrl_n

Parametrised N-stage pipeline controller and inter-stage payload register chain for the multi-cycle/pipelined CPU family. It generalises the fixed five-stage valid / allow_in / over handshake:

- stage count and payload width are parameters;
- a per-stage flush mask replaces the all-or-nothing cancel;
- retire reporting is built in;
- optional performance counters can be compiled in.

Stage datapaths (fetch, decode, exe, mem, wb, ...) sit outside this block. They consume `stage_data` and report `stage_over`.

## Interface
Parameters:
- NSTAGE, 5, number of pipeline stages (≥2)
- DW, 64, payload width per stage register
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- in_valid  in  1  producer offers entry to stage 0
- in_data  in  DW  entry payload
- in_ready  out  1  entry accepted this cycle when in_valid & in_ready
- stage_over  in  NSTAGE  stage i finished its current entry (combinational from datapath)
- stage_data_next  in  NSTAGE*DW  payload stage i hands to stage i+1 (slice NSTAGE-1 unused)
- cancel  in  1  flush request
- flush_mask  in  NSTAGE  stages invalidated when cancel=1
- stage_valid  out  NSTAGE  stage holds a live entry
- stage_data  out  NSTAGE*DW  registered payload of each stage
- stage_allow_in  out  NSTAGE  stage can accept an entry
- stage_fire  out  NSTAGE  stage i hands off (to i+1, or retires) this cycle
- ret_valid  out  1  last stage retires this cycle
- perf_clr  in  1  synchronous clear of all counters
- stall_cnt  out  NSTAGE*CNT_W  per-stage stall cycles
- ret_cnt  out  CNT_W  retired entries

## Operation
- kill[i] = cancel & flush_mask[i].
- over_eff[i] = valid[i] & stage_over[i] & ~kill[i].
- allow_in[i] = ~valid[i] | (over[i] & allow_in[i+1]). allow_in[NSTAGE] = 1.
- fire[i] = over_eff[i] & allow_in[i+1]. ret_valid = fire[NSTAGE-1].
- in_ready = allow_in[0] | kill[0].
- Stage 0 load condition: in_valid & in_ready. A stage-0 load while kill[0] is accepted and discarded: stage 0 valid ← 0.
- valid[i] update, in priority order:
  - reset → 0
  - kill[i] → 0
  - allow_in[i] → source handoff (in accept for i=0, fire[i-1] for i>0)
  - otherwise hold
- data[i] loads in_data (i=0) or stage_data_next slice i-1 whenever the source handoff fires and kill[i]=0. Otherwise it holds.
- Entries from a killed stage never propagate and never retire.
- Entries in unmasked stages continue normally in the same cycle.
- Reset values: all stage_valid 0, stage_data 0, counters 0.
- Combinational outputs after reset with zero inputs: in_ready 1, stage_allow_in all 1, stage_fire 0, ret_valid 0.

## Timing
- Entry accepted at edge t is visible in stage 0 during cycle t+1.
- Minimum latency to ret_valid is NSTAGE cycles after acceptance; throughput is one entry per cycle.
- The allow_in chain is combinational from the last stage back to in_ready, so its path depth is O(NSTAGE).
- The stage_over → in_ready combinational path is permitted.
- Counters update at the clock edge. perf_clr wins over increment.

## Configuration
- PIPE_PERF_EN defined:
  - stall_cnt[i] increments each cycle valid[i] & ~fire[i] & ~kill[i];
  - ret_cnt increments on ret_valid;
  - all counters saturate at all-ones.
- PIPE_PERF_EN undefined: counter registers are absent, stall_cnt/ret_cnt are tied 0, and perf_clr is ignored. Ports exist in both builds.

## Structure
- Shared package pipe_pkg holds:
  - default NSTAGE/DW/CNT_W constants;
  - stage index constants for the 5-stage CPU (IF=0 … WB=4);
  - the standard flush masks: syscall/eret flush of all non-fetch stages.
- One sub-module, pipe_slot: one stage's valid bit plus DW payload register, with load/kill/reset priority. It is instantiated NSTAGE times in a generate loop.

## Test plan
- Reset: hold resetn=0 two cycles mid-stream →
  - stage_valid=0, stage_data=0, in_ready=1, counters 0;
  - no ret_valid the cycle after release.
- Streaming (NSTAGE=5): stage_over all 1, in_data=1,2,3 on consecutive cycles →
  - ret_valid first asserted 5 cycles after accepting 1;
  - retired payloads appear in order 1,2,3 on consecutive cycles.
- Stall: full pipe, stage_over[2]=0 for 3 cycles →
  - stages 0–2 hold, in_ready=0, stage 3 becomes a bubble;
  - stall_cnt[2]=3 (PIPE_PERF_EN).
- Partial flush: full pipe, cancel=1, flush_mask=5'b01111, in_valid=1 →
  - next cycle stages 0–3 invalid and the offered entry is dropped;
  - stage 4 retires normally (ret_cnt +1).
- Full flush: cancel=1, flush_mask=5'b11111, stage_over[4]=1 → ret_valid=0 and all stages invalid next cycle.
- Saturation: CNT_W=4, 20 retires → ret_cnt=15; then perf_clr=1 → 0 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined CPU family.
//  - Default geometry for pipe_ctrl_n (stage count, payload width, counter width).
//  - Stage indices of the classic five-stage CPU (IF=0 .. WB=4).
//  - Standard flush masks for that CPU.
package pipe_pkg;

  localparam int unsigned NStageDef = 5;
  localparam int unsigned DwDef     = 64;
  localparam int unsigned CntWDef   = 32;

  localparam int unsigned CpuNStage = 5;

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StEx  = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4
  } cpu_stage_e;

  // One-hot mask bit for a stage of the five-stage CPU.
  function automatic logic [CpuNStage-1:0] stage_bit(cpu_stage_e s);
    return CpuNStage'(1) << s;
  endfunction

  localparam logic [CpuNStage-1:0] FlushNone = 5'b00000;
  localparam logic [CpuNStage-1:0] FlushAll  = 5'b11111;
  // syscall / eret: everything behind fetch is squashed, fetch refills from the new PC.
  localparam logic [CpuNStage-1:0] FlushExc  = 5'b11110;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline stage register: live-entry valid bit plus DW-bit payload.
// Update priority: reset, kill, then (when the stage can accept) the incoming handoff.
// Ports:
//   clk, resetn  clock and synchronous active-low reset
//   allow_in_i   stage can accept an entry this cycle
//   load_i       upstream hands an entry to this stage this cycle
//   kill_i       flush this stage
//   data_i       incoming payload
//   valid_o      stage holds a live entry
//   data_o       registered payload
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned DW = DwDef
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          allow_in_i,
  input  logic          load_i,
  input  logic          kill_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (kill_i) begin
      valid_d = 1'b0;
    end else if (allow_in_i) begin
      valid_d = load_i;
    end
    // A killed handoff never lands, so the payload only moves with a surviving load.
    if (load_i && !kill_i) begin
      data_d = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_ctrl_n.sv
// N-stage pipeline controller with inter-stage payload registers.
// Handshake: a stage fires when its entry is over and the next stage can accept;
// the last stage firing is a retire. cancel with flush_mask squashes selected stages.
// Build option: define PIPE_PERF_EN to compile in per-stage stall counters and a
// retire counter (saturating, cleared by perf_clr). Without it the counter outputs read 0.
// Ports:
//   clk, resetn       clock and synchronous active-low reset
//   in_valid/in_data  entry offered to stage 0; in_ready accepts it
//   stage_over        per-stage "finished current entry" from the datapaths
//   stage_data_next   payload stage i hands to stage i+1 (top slice unused)
//   cancel/flush_mask flush request and the stages it invalidates
//   stage_valid/stage_data/stage_allow_in/stage_fire  per-stage status and payload
//   ret_valid         last stage retires this cycle
//   perf_clr, stall_cnt, ret_cnt  performance counters
module pipe_ctrl_n
  import pipe_pkg::*;
#(
  parameter int unsigned NSTAGE = NStageDef,
  parameter int unsigned DW     = DwDef,
  parameter int unsigned CNT_W  = CntWDef
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  input  logic [DW-1:0]           in_data,
  output logic                    in_ready,
  input  logic [NSTAGE-1:0]       stage_over,
  input  logic [NSTAGE*DW-1:0]    stage_data_next,
  input  logic                    cancel,
  input  logic [NSTAGE-1:0]       flush_mask,
  output logic [NSTAGE-1:0]       stage_valid,
  output logic [NSTAGE*DW-1:0]    stage_data,
  output logic [NSTAGE-1:0]       stage_allow_in,
  output logic [NSTAGE-1:0]       stage_fire,
  output logic                    ret_valid,
  input  logic                    perf_clr,
  output logic [NSTAGE*CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0]        ret_cnt
);

  logic [NSTAGE-1:0]         valid;
  logic [NSTAGE-1:0]         kill;
  logic [NSTAGE-1:0]         over_eff;
  logic [NSTAGE:0]           allow_c;
  logic [NSTAGE-1:0]         fire;
  logic [NSTAGE-1:0]         load;
  logic [NSTAGE-1:0][DW-1:0] slot_din;

  // The last stage's outgoing payload has nowhere to go.
  logic unused_data_next;
  assign unused_data_next = ^stage_data_next[NSTAGE*DW-1 -: DW];

  // Whole handshake in one block: allow_in ripples from the tail back to in_ready.
  always_comb begin
    kill     = {NSTAGE{cancel}} & flush_mask;
    over_eff = valid & stage_over & ~kill;
    allow_c  = '1;
    for (int i = int'(NSTAGE) - 1; i >= 0; i--) begin
      allow_c[i] = ~valid[i] | (over_eff[i] & allow_c[i+1]);
    end
    fire = over_eff & allow_c[NSTAGE:1];
    // A killed stage 0 may still take the offered entry; the slot then discards it.
    in_ready = allow_c[0] | kill[0];
    load[0]  = in_valid & in_ready;
    for (int i = 1; i < int'(NSTAGE); i++) begin
      load[i] = fire[i-1];
    end
    slot_din[0] = in_data;
    for (int i = 1; i < int'(NSTAGE); i++) begin
      slot_din[i] = stage_data_next[(i-1)*DW +: DW];
    end
  end

  for (genvar g = 0; g < NSTAGE; g++) begin : g_slot
    pipe_slot #(
      .DW(DW)
    ) u_slot (
      .clk       (clk),
      .resetn    (resetn),
      .allow_in_i(allow_c[g]),
      .load_i    (load[g]),
      .kill_i    (kill[g]),
      .data_i    (slot_din[g]),
      .valid_o   (valid[g]),
      .data_o    (stage_data[g*DW +: DW])
    );
  end

  assign stage_valid    = valid;
  assign stage_allow_in = allow_c[NSTAGE-1:0];
  assign stage_fire     = fire;
  assign ret_valid      = fire[NSTAGE-1];

`ifdef PIPE_PERF_EN
  logic [NSTAGE-1:0][CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]             ret_cnt_q, ret_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
      ret_cnt_d   = '0;
    end else begin
      for (int i = 0; i < int'(NSTAGE); i++) begin
        // Stalled: holding a live entry that neither moves on nor gets flushed.
        if (valid[i] && !fire[i] && !kill[i] && !(&stall_cnt_q[i])) begin
          stall_cnt_d[i] = stall_cnt_q[i] + CNT_W'(1);
        end
      end
      if (fire[NSTAGE-1] && !(&ret_cnt_q)) begin
        ret_cnt_d = ret_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign ret_cnt   = ret_cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign stall_cnt       = '0;
  assign ret_cnt         = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Directed bench for pipe_ctrl_n (NSTAGE=5, DW=16, CNT_W=4). The modelled datapath
// adds 1 to the payload at every stage, so an entry x retires carrying x+4.
module tb_pipe_ctrl_n;

  localparam int unsigned NS = 5;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
`ifdef PIPE_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic             in_ready;
  logic [NS-1:0]    stage_over;
  logic [NS*DW-1:0] stage_data_next;
  logic             cancel;
  logic [NS-1:0]    flush_mask;
  logic [NS-1:0]    stage_valid;
  logic [NS*DW-1:0] stage_data;
  logic [NS-1:0]    stage_allow_in;
  logic [NS-1:0]    stage_fire;
  logic             ret_valid;
  logic             perf_clr;
  logic [NS*CW-1:0] stall_cnt;
  logic [CW-1:0]    ret_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_ctrl_n #(
    .NSTAGE(NS),
    .DW    (DW),
    .CNT_W (CW)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .stage_over     (stage_over),
    .stage_data_next(stage_data_next),
    .cancel         (cancel),
    .flush_mask     (flush_mask),
    .stage_valid    (stage_valid),
    .stage_data     (stage_data),
    .stage_allow_in (stage_allow_in),
    .stage_fire     (stage_fire),
    .ret_valid      (ret_valid),
    .perf_clr       (perf_clr),
    .stall_cnt      (stall_cnt),
    .ret_cnt        (ret_cnt)
  );

  always_comb begin
    stage_data_next = '0;
    for (int i = 0; i < NS; i++) begin
      stage_data_next[i*DW +: DW] = stage_data[i*DW +: DW] + 16'd1;
    end
  end

  typedef struct packed {
    logic          iv;
    logic [15:0]   d;
    logic [NS-1:0] ov;
    logic          can;
    logic [NS-1:0] msk;
    logic [NS-1:0] ev;
    logic          er;
    logic [NS-1:0] ef;
    logic          eret;
    logic [15:0]   ed4;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic iv, input logic [15:0] d, input logic [NS-1:0] ov,
                     input logic can, input logic [NS-1:0] msk, input logic [NS-1:0] ev,
                     input logic er, input logic [NS-1:0] ef, input logic eret,
                     input logic [15:0] ed4);
    vec_t v;
    v.iv = iv; v.d = d; v.ov = ov; v.can = can; v.msk = msk;
    v.ev = ev; v.er = er; v.ef = ef; v.eret = eret; v.ed4 = ed4;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pexp(input int v);
    return PerfEn ? 64'(v) : 64'd0;
  endfunction

  task automatic chk_cnt(input string tag, input int s0, input int s1, input int s2,
                         input int s3, input int s4, input int r);
    int exp_s[NS];
    exp_s = '{s0, s1, s2, s3, s4};
    for (int i = 0; i < NS; i++) begin
      chk($sformatf("%s stall_cnt[%0d]", tag, i), stall_cnt[i*CW +: CW], pexp(exp_s[i]));
    end
    chk($sformatf("%s ret_cnt", tag), ret_cnt, pexp(r));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    resetn = 1'b0; in_valid = 1'b0; in_data = '0; stage_over = '0;
    cancel = 1'b0; flush_mask = '0; perf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset stage_valid", stage_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset allow_in", stage_allow_in, 5'b11111);
    chk("reset stage_fire", stage_fire, 0);
    chk("reset ret_valid", ret_valid, 0);
    for (int i = 0; i < NS; i++) chk($sformatf("reset data[%0d]", i), stage_data[i*DW +: DW], 0);
    chk_cnt("reset", 0, 0, 0, 0, 0, 0);
    resetn = 1'b1;

    //   iv  data    over      can  mask      valid     rdy  fire      ret  data4
    // streaming 1,2,3
    row(1, 16'd1,  5'b11111, 0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 16'd0);
    row(1, 16'd2,  5'b11111, 0, 5'b00000, 5'b00001, 1, 5'b00001, 0, 16'd0);
    row(1, 16'd3,  5'b11111, 0, 5'b00000, 5'b00011, 1, 5'b00011, 0, 16'd0);
    row(0, 16'd0,  5'b11111, 0, 5'b00000, 5'b00111, 1, 5'b00111, 0, 16'd0);
    row(0, 16'd0,  5'b11111, 0, 5'b00000, 5'b01110, 1, 5'b01110, 0, 16'd0);
    row(0, 16'd0,  5'b11111, 0, 5'b00000, 5'b11100, 1, 5'b11100, 1, 16'd5);
    row(0, 16'd0,  5'b11111, 0, 5'b00000, 5'b11000, 1, 5'b11000, 1, 16'd6);
    row(0, 16'd0,  5'b11111, 0, 5'b00000, 5'b10000, 1, 5'b10000, 1, 16'd7);
    // fill, then stall stage 2 for three cycles
    row(1, 16'd10, 5'b11111, 0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 16'd0);
    row(1, 16'd11, 5'b11111, 0, 5'b00000, 5'b00001, 1, 5'b00001, 0, 16'd0);
    row(1, 16'd12, 5'b11111, 0, 5'b00000, 5'b00011, 1, 5'b00011, 0, 16'd0);
    row(1, 16'd13, 5'b11111, 0, 5'b00000, 5'b00111, 1, 5'b00111, 0, 16'd0);
    row(1, 16'd14, 5'b11111, 0, 5'b00000, 5'b01111, 1, 5'b01111, 0, 16'd0);
    row(1, 16'd99, 5'b11011, 0, 5'b00000, 5'b11111, 0, 5'b11000, 1, 16'd14);
    row(1, 16'd99, 5'b11011, 0, 5'b00000, 5'b10111, 0, 5'b10000, 1, 16'd15);
    row(1, 16'd99, 5'b11011, 0, 5'b00000, 5'b00111, 0, 5'b00000, 0, 16'd0);
    row(1, 16'd20, 5'b11111, 0, 5'b00000, 5'b00111, 1, 5'b00111, 0, 16'd0);
    row(1, 16'd21, 5'b11111, 0, 5'b00000, 5'b01111, 1, 5'b01111, 0, 16'd0);
    // partial flush of stages 0-3 with an entry on offer
    row(1, 16'd22, 5'b11111, 1, 5'b01111, 5'b11111, 1, 5'b10000, 1, 16'd16);
    row(0, 16'd0,  5'b11111, 0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 16'd0);
    // refill, then full flush
    row(1, 16'd30, 5'b11111, 0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 16'd0);
    row(1, 16'd31, 5'b11111, 0, 5'b00000, 5'b00001, 1, 5'b00001, 0, 16'd0);
    row(1, 16'd32, 5'b11111, 0, 5'b00000, 5'b00011, 1, 5'b00011, 0, 16'd0);
    row(1, 16'd33, 5'b11111, 0, 5'b00000, 5'b00111, 1, 5'b00111, 0, 16'd0);
    row(1, 16'd34, 5'b11111, 0, 5'b00000, 5'b01111, 1, 5'b01111, 0, 16'd0);
    row(0, 16'd0,  5'b11111, 1, 5'b11111, 5'b11111, 1, 5'b00000, 0, 16'd0);
    row(0, 16'd0,  5'b11111, 0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 16'd0);

    @(posedge clk);
    #1;
    for (int k = 0; k < tbl.size(); k++) begin
      v = tbl[k];
      in_valid = v.iv; in_data = v.d; stage_over = v.ov; cancel = v.can; flush_mask = v.msk;
      #1;
      chk($sformatf("r%0d stage_valid", k), stage_valid, v.ev);
      chk($sformatf("r%0d in_ready", k), in_ready, v.er);
      chk($sformatf("r%0d stage_fire", k), stage_fire, v.ef);
      chk($sformatf("r%0d ret_valid", k), ret_valid, v.eret);
      if (v.eret) chk($sformatf("r%0d ret data", k), stage_data[4*DW +: DW], v.ed4);
      @(posedge clk);
      #1;
    end
    cancel = 1'b0; flush_mask = '0;

    // Three stall cycles on stages 0-2; six retires so far.
    chk_cnt("after table", 3, 3, 3, 0, 0, 6);

    // Saturation and clear priority: 20 more retires, perf_clr coincides with a retire.
    for (int c = 0; c < 22; c++) begin
      in_valid   = (c < 20);
      in_data    = 16'(100 + c);
      stage_over = '1;
      perf_clr   = (c == 19);
      #1;
      if (c == 19) chk("sat ret_cnt", ret_cnt, pexp(15));
      if (c == 20) begin
        chk_cnt("after clr", 0, 0, 0, 0, 0, 0);
        chk("drain ret_valid", ret_valid, 1);
        chk("drain ret data", stage_data[4*DW +: DW], 16'd119);
      end
      if (c == 21) chk("post clr ret_cnt", ret_cnt, pexp(1));
      @(posedge clk);
      #1;
    end
    perf_clr = 1'b0;

    // Reset mid-stream.
    in_valid = 1'b1; in_data = 16'h55;
    chk("pre-reset pipe busy", stage_valid != 0, 1);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid reset stage_valid", stage_valid, 0);
    chk("mid reset in_ready", in_ready, 1);
    for (int i = 0; i < NS; i++) chk($sformatf("mid reset data[%0d]", i), stage_data[i*DW +: DW], 0);
    chk_cnt("mid reset", 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    resetn   = 1'b1;
    @(posedge clk);
    #1;
    chk("post release ret_valid", ret_valid, 0);
    chk("post release stage_valid", stage_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
